// File: rtl/mips_dmem_ahb_master.sv
// MIPS MEM-stage load/store port to AHB-Lite SINGLE-burst master.
// Optional posted stores: define DMEM_WRITE_POST_EN.
module mips_dmem_ahb_master #(
    parameter int ADDR_W         = 32,
    parameter bit MISALIGN_CHECK = 1'b1
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_size,
    input  logic              mem_signed,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_stall,
    output logic              mem_err,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic              HWRITE,
    output logic [31:0]       HWDATA,
    input  logic              HREADY,
    input  logic              HRESP,
    input  logic [31:0]       HRDATA
);

`ifdef DMEM_WRITE_POST_EN
    localparam bit POST_EN = 1'b1;
`else
    localparam bit POST_EN = 1'b0;
`endif

    typedef enum logic {
        S_IDLE,
        S_DATA
    } state_t;

    state_t      st;
    logic [1:0]  a_q;
    logic [1:0]  sz_q;
    logic        sgn_q;
    logic        we_q;
    logic [31:0] wd_q;
    logic [31:0] rd_q;

    logic        req;
    logic        misal;
    logic        ok;
    logic        issue;
    logic        done;
    logic [31:0] wrep;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] algn;

    // request qualification and the combinational address phase
    always_comb begin
        req    = mem_req & HRESETn;
        misal  = (mem_size == 2'b01 && mem_addr[0]) ||
                 (mem_size[1] && mem_addr[1:0] != 2'b00);
        ok     = !(MISALIGN_CHECK && misal);
        issue  = (st == S_IDLE) && req && ok;
        done   = (st == S_DATA) && HREADY;
        HTRANS = issue ? 2'b10 : 2'b00;
        HWRITE = issue & mem_we;
        HSIZE  = {1'b0, mem_size};
        HBURST = 3'b000;
        HADDR  = '0;
        if (issue) begin
            HADDR = {mem_addr[ADDR_W-1:2],
                     misal ? 2'b00 : mem_addr[1:0]};
        end
        HWDATA = wd_q;
    end

    // replicate store data across the byte lanes
    always_comb begin
        unique case (mem_size)
            2'b00:   wrep = {4{mem_wdata[7:0]}};
            2'b01:   wrep = {2{mem_wdata[15:0]}};
            default: wrep = mem_wdata;
        endcase
    end

    // select and extend the load lane from the latched offset/size
    always_comb begin
        unique case (a_q)
            2'b00:   b = HRDATA[7:0];
            2'b01:   b = HRDATA[15:8];
            2'b10:   b = HRDATA[23:16];
            default: b = HRDATA[31:24];
        endcase
        h = a_q[1] ? HRDATA[31:16] : HRDATA[15:0];
        unique case (sz_q)
            2'b00:   algn = {{24{sgn_q & b[7]}}, b};
            2'b01:   algn = {{16{sgn_q & h[15]}}, h};
            default: algn = HRDATA;
        endcase
    end

    // CPU-side stall, error pulse and load data
    always_comb begin
        mem_err   = ((st == S_IDLE) && req && !ok) ||
                    (done && HRESP);
        mem_stall = 1'b0;
        if (st == S_IDLE) begin
            mem_stall = issue &&
                        !(POST_EN && mem_we && HREADY);
        end else if (POST_EN && we_q) begin
            mem_stall = req;
        end else begin
            mem_stall = !HREADY;
        end
        mem_rdata = rd_q;
        if (done && HRESP) begin
            mem_rdata = '0;
        end else if (done && !we_q) begin
            mem_rdata = algn;
        end
    end

    // transfer FSM: latch access on address accept, finish on HREADY
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            st    <= S_IDLE;
            a_q   <= 2'b00;
            sz_q  <= 2'b00;
            sgn_q <= 1'b0;
            we_q  <= 1'b0;
            wd_q  <= '0;
            rd_q  <= '0;
        end else begin
            case (st)
                S_IDLE: begin
                    if (issue && HREADY) begin
                        st    <= S_DATA;
                        a_q   <= mem_addr[1:0];
                        sz_q  <= mem_size;
                        sgn_q <= mem_signed;
                        we_q  <= mem_we;
                        wd_q  <= wrep;
                    end
                end
                default: begin
                    if (HREADY) begin
                        st <= S_IDLE;
                        if (!we_q) begin
                            rd_q <= mem_rdata;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_dmem_ahb_master.sv
// Self-checking bench for mips_dmem_ahb_master.
// Random and directed accesses against a behavioural model.
module tb_mips_dmem_ahb_master;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic        mem_signed;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_stall;
    logic        mem_err;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HRESP;
    logic [31:0] HRDATA;

`ifdef DMEM_WRITE_POST_EN
    localparam bit POST = 1'b1;
`else
    localparam bit POST = 1'b0;
`endif

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          issue_cyc = 0;
    logic [31:0] last_rd = '0;
    bit          last_ok = 1'b1;
    bit          ap_wait = 1'b0;

    mips_dmem_ahb_master #(
        .ADDR_W(32),
        .MISALIGN_CHECK(1'b1)
    ) dut (
        .HCLK(HCLK),
        .HRESETn(HRESETn),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_size(mem_size),
        .mem_signed(mem_signed),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_stall(mem_stall),
        .mem_err(mem_err),
        .HADDR(HADDR),
        .HTRANS(HTRANS),
        .HSIZE(HSIZE),
        .HBURST(HBURST),
        .HWRITE(HWRITE),
        .HWDATA(HWDATA),
        .HREADY(HREADY),
        .HRESP(HRESP),
        .HRDATA(HRDATA)
    );

    always #5 HCLK = ~HCLK;

    always @(posedge HCLK) begin
        cyc++;
        ap_wait <= HRESETn && HTRANS == 2'b10 && !HREADY;
    end

    always @(negedge HCLK) begin
        if (ap_wait && HRESETn && !mem_req) begin
            $error("mem_req withdrawn during address-phase wait");
        end
    end

    function automatic logic [31:0] ref_load(input logic [1:0] sz,
                                             input bit sgn,
                                             input logic [31:0] addr,
                                             input logic [31:0] hr);
        longint v;
        int     bits;
        int     sh;
        if (sz == 2'd0) begin
            bits = 8;
            sh   = 8 * int'(addr[1:0]);
        end else if (sz == 2'd1) begin
            bits = 16;
            sh   = 16 * int'(addr[1]);
        end else begin
            return hr;
        end
        v = longint'(hr >> sh) & ((longint'(1) << bits) - 1);
        if (sgn && v >= (longint'(1) << (bits - 1)))
            v = v - (longint'(1) << bits);
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] sz,
                                              input logic [31:0] wd);
        if (sz == 2'd0) return {24'd0, wd[7:0]} * 32'h0101_0101;
        if (sz == 2'd1) return {16'd0, wd[15:0]} * 32'h0001_0001;
        return wd;
    endfunction

    task automatic run_access(input string nm, input bit we,
                              input logic [1:0] sz, input bit sgn,
                              input logic [31:0] addr,
                              input logic [31:0] wd,
                              input logic [31:0] hr,
                              input int aw, input int dw,
                              input bit er, input bit gap);
        bit          posted;
        logic [31:0] exp;
        posted     = POST && we;
        mem_req    = 1'b1;
        mem_we     = we;
        mem_size   = sz;
        mem_signed = sgn;
        mem_addr   = addr;
        mem_wdata  = wd;
        for (int i = 0; i <= aw; i++) begin
            HREADY = (i == aw);
            HRESP  = 1'b0;
            @(negedge HCLK);
            total++;
            if ({HTRANS, HWRITE, HADDR, HSIZE, mem_stall, mem_err} !==
                {2'b10, we, addr, 1'b0, sz, (!posted || i != aw), 1'b0}) begin
                bad++;
                $display("FAIL %s addr-phase %0d: got trans=%b wr=%b addr=%h size=%b stall=%b err=%b want trans=10 wr=%b addr=%h size=0%b stall=%b err=0",
                         nm, i, HTRANS, HWRITE, HADDR, HSIZE, mem_stall,
                         mem_err, we, addr, sz, (!posted || i != aw));
            end
            if (i == aw) issue_cyc = cyc;
            @(posedge HCLK);
            #1;
        end
        if (posted) mem_req = 1'b0;
        for (int i = 0; i < dw + int'(er); i++) begin
            HREADY = 1'b0;
            HRESP  = (i >= dw);
            @(negedge HCLK);
            total++;
            if ({HTRANS, mem_stall, mem_err} !== {2'b00, !posted, 1'b0}) begin
                bad++;
                $display("FAIL %s wait %0d: got trans=%b stall=%b err=%b want trans=00 stall=%b err=0",
                         nm, i, HTRANS, mem_stall, mem_err, !posted);
            end
            @(posedge HCLK);
            #1;
        end
        HREADY = 1'b1;
        HRESP  = er;
        HRDATA = hr;
        @(negedge HCLK);
        if (we) exp = ref_wdata(sz, wd);
        else if (er) exp = '0;
        else exp = ref_load(sz, sgn, addr, hr);
        total++;
        if ({HTRANS, mem_stall, mem_err} !== {2'b00, 1'b0, er}) begin
            bad++;
            $display("FAIL %s done-ctl: got trans=%b stall=%b err=%b want trans=00 stall=0 err=%b",
                     nm, HTRANS, mem_stall, mem_err, er);
        end
        total++;
        if (we) begin
            if (HWDATA !== exp) begin
                bad++;
                $display("FAIL %s hwdata: got %h want %h", nm, HWDATA, exp);
            end
        end else begin
            if (mem_rdata !== exp) begin
                bad++;
                $display("FAIL %s rdata: got %h want %h", nm, mem_rdata, exp);
            end
            last_rd = exp;
            last_ok = !er;
        end
        @(posedge HCLK);
        #1;
        mem_req = 1'b0;
        HRESP   = 1'b0;
        HRDATA  = $urandom;
        if (gap) begin
            @(negedge HCLK);
            total++;
            if ({mem_stall, HTRANS} !== 3'b000 ||
                (last_ok && mem_rdata !== last_rd)) begin
                bad++;
                $display("FAIL %s hold: got stall=%b trans=%b rdata=%h want stall=0 trans=00 rdata=%h",
                         nm, mem_stall, HTRANS, mem_rdata, last_rd);
            end
            @(posedge HCLK);
            #1;
        end
    endtask

    task automatic test_reset();
        HRESETn    = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_size   = 2'b10;
        mem_signed = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        HREADY     = 1'b1;
        HRESP      = 1'b0;
        HRDATA     = '0;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        total++;
        if ({HTRANS, HWRITE, HADDR, HWDATA, mem_rdata, mem_stall,
             mem_err, HBURST} !== '0) begin
            bad++;
            $display("FAIL reset: got trans=%b wr=%b addr=%h wdata=%h rdata=%h stall=%b err=%b burst=%b want all 0",
                     HTRANS, HWRITE, HADDR, HWDATA, mem_rdata,
                     mem_stall, mem_err, HBURST);
        end
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        last_rd = '0;
        last_ok = 1'b1;
    endtask

    task automatic test_directed();
        run_access("ld_word", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,
                   32'hDEAD_BEEF, 0, 0, 1'b0, 1'b1);
        run_access("ld_sbyte", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0,
                   32'h8011_2233, 0, 0, 1'b0, 1'b1);
        total++;
        if (last_rd !== 32'hFFFF_FF80) begin
            bad++;
            $display("FAIL sbyte_model: got %h want ffffff80", last_rd);
        end
        run_access("ld_uhalf", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0,
                   32'h8011_2233, 0, 0, 1'b0, 1'b1);
        run_access("st_byte", 1'b1, 2'b00, 1'b0, 32'h21, 32'hA5,
                   32'h0, 0, 0, 1'b0, 1'b1);
        run_access("st_half", 1'b1, 2'b01, 1'b0, 32'h22, 32'h1234_BEEF,
                   32'h0, 0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_wait_states();
        run_access("ld_3wait", 1'b0, 2'b10, 1'b0, 32'h30, 32'h0,
                   32'h0BAD_F00D, 0, 3, 1'b0, 1'b1);
        run_access("ld_aphold", 1'b0, 2'b10, 1'b0, 32'h34, 32'h0,
                   32'h1357_9BDF, 2, 1, 1'b0, 1'b1);
    endtask

    task automatic test_misaligned();
        logic [31:0] ad [4] = '{32'h02, 32'h11, 32'h13, 32'h06};
        logic [1:0]  sz [4] = '{2'b10, 2'b01, 2'b10, 2'b11};
        for (int k = 0; k < 4; k++) begin
            mem_req  = 1'b1;
            mem_we   = 1'b0;
            mem_size = sz[k];
            mem_addr = ad[k];
            HREADY   = 1'b1;
            @(negedge HCLK);
            total++;
            if ({HTRANS, mem_stall, mem_err} !== 4'b0001 ||
                (last_ok && mem_rdata !== last_rd)) begin
                bad++;
                $display("FAIL misal %0d: got trans=%b stall=%b err=%b rdata=%h want trans=00 stall=0 err=1 rdata=%h",
                         k, HTRANS, mem_stall, mem_err, mem_rdata, last_rd);
            end
            @(posedge HCLK);
            #1;
            mem_req = 1'b0;
            @(negedge HCLK);
            total++;
            if (mem_err !== 1'b0) begin
                bad++;
                $display("FAIL misal_pulse %0d: got err=%b want 0", k, mem_err);
            end
            @(posedge HCLK);
            #1;
        end
    endtask

    task automatic test_error();
        run_access("ld_err", 1'b0, 2'b10, 1'b0, 32'h50, 32'h0,
                   32'hFFFF_FFFF, 0, 0, 1'b1, 1'b1);
        run_access("ld_after_err", 1'b0, 2'b01, 1'b1, 32'h52, 32'h0,
                   32'h8000_0000, 0, 1, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        int c0;
        run_access("b2b_0", 1'b0, 2'b10, 1'b0, 32'h60, 32'h0,
                   32'h1111_1111, 0, 0, 1'b0, 1'b0);
        c0 = issue_cyc;
        run_access("b2b_1", 1'b0, 2'b00, 1'b0, 32'h65, 32'h0,
                   32'h2222_C322, 0, 0, 1'b0, 1'b1);
        total++;
        if (issue_cyc - c0 !== 2) begin
            bad++;
            $display("FAIL b2b_spacing: got %0d cycles want 2", issue_cyc - c0);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [1:0]  sz;
            logic [31:0] ad;
            int          lo;
            sz = 2'($urandom_range(0, 3));
            if (sz == 2'd0) lo = $urandom_range(0, 3);
            else if (sz == 2'd1) lo = 2 * $urandom_range(0, 1);
            else lo = 0;
            ad = ($urandom & 32'h0000_0FFC) | 32'(lo);
            run_access("rand", 1'($urandom_range(0, 1)), sz,
                       1'($urandom_range(0, 1)), ad, $urandom,
                       $urandom, $urandom_range(0, 2),
                       $urandom_range(0, 3),
                       ($urandom_range(0, 7) == 0),
                       1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid();
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_size = 2'b10;
        mem_addr = 32'h70;
        HREADY   = 1'b1;
        @(posedge HCLK);
        #1;
        HREADY = 1'b0;
        @(negedge HCLK);
        #1;
        HRESETn = 1'b0;
        mem_req = 1'b0;
        #1;
        total++;
        if ({HTRANS, mem_stall, mem_err, mem_rdata, HWDATA} !== '0) begin
            bad++;
            $display("FAIL reset_mid: got trans=%b stall=%b err=%b rdata=%h wdata=%h want all 0",
                     HTRANS, mem_stall, mem_err, mem_rdata, HWDATA);
        end
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        HREADY  = 1'b1;
        @(negedge HCLK);
        total++;
        if ({HTRANS, mem_stall} !== 3'b000) begin
            bad++;
            $display("FAIL reset_noretry: got trans=%b stall=%b want 00/0",
                     HTRANS, mem_stall);
        end
        @(posedge HCLK);
        #1;
        last_rd = '0;
        last_ok = 1'b1;
    endtask

`ifdef DMEM_WRITE_POST_EN
    task automatic test_posted();
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_size  = 2'b10;
        mem_addr  = 32'h40;
        mem_wdata = 32'h1122_3344;
        HREADY    = 1'b1;
        @(negedge HCLK);
        total++;
        if ({HTRANS, HWRITE, mem_stall} !== 4'b1010) begin
            bad++;
            $display("FAIL post_st: got trans=%b wr=%b stall=%b want 10/1/0",
                     HTRANS, HWRITE, mem_stall);
        end
        @(posedge HCLK);
        #1;
        mem_we   = 1'b0;
        mem_addr = 32'h44;
        HREADY   = 1'b0;
        @(negedge HCLK);
        total++;
        if ({HTRANS, mem_stall} !== 3'b001 || HWDATA !== 32'h1122_3344) begin
            bad++;
            $display("FAIL post_wait: got trans=%b stall=%b wdata=%h want 00/1/11223344",
                     HTRANS, mem_stall, HWDATA);
        end
        @(posedge HCLK);
        #1;
        HREADY = 1'b1;
        @(negedge HCLK);
        total++;
        if ({HTRANS, mem_stall, mem_err} !== 4'b0010) begin
            bad++;
            $display("FAIL post_done: got trans=%b stall=%b err=%b want 00/1/0",
                     HTRANS, mem_stall, mem_err);
        end
        @(posedge HCLK);
        #1;
        @(negedge HCLK);
        total++;
        if ({HTRANS, HWRITE, HADDR, mem_stall} !== {2'b10, 1'b0, 32'h44, 1'b1}) begin
            bad++;
            $display("FAIL post_ld_ap: got trans=%b wr=%b addr=%h stall=%b want 10/0/44/1",
                     HTRANS, HWRITE, HADDR, mem_stall);
        end
        @(posedge HCLK);
        #1;
        HRDATA = 32'hCAFE_0001;
        @(negedge HCLK);
        total++;
        if (mem_stall !== 1'b0 || mem_rdata !== 32'hCAFE_0001) begin
            bad++;
            $display("FAIL post_ld_done: got stall=%b rdata=%h want 0/cafe0001",
                     mem_stall, mem_rdata);
        end
        last_rd = 32'hCAFE_0001;
        last_ok = 1'b1;
        @(posedge HCLK);
        #1;
        mem_req = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_wait_states();
        test_misaligned();
        test_error();
        test_back_to_back();
        test_random();
`ifdef DMEM_WRITE_POST_EN
        test_posted();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
